// File: rtl/bcd_setpoint_entry_pkg.sv
// Shared definitions for the BCD setpoint entry block: digit geometry,
// one-hot digit selects, the edit FSM state type and small BCD helpers.
package bcd_setpoint_entry_pkg;

  localparam int DIGIT_W      = 4;
  localparam int NUM_DIGITS   = 3;
  localparam int BCD_W        = DIGIT_W * NUM_DIGITS;
  localparam int SETPOINT_MAX = 999;
  localparam int BIN_W        = $clog2(SETPOINT_MAX + 1);

  localparam logic [NUM_DIGITS-1:0] DIGIT_ONES     = 3'b001;
  localparam logic [NUM_DIGITS-1:0] DIGIT_TENS     = 3'b010;
  localparam logic [NUM_DIGITS-1:0] DIGIT_HUNDREDS = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Increment one BCD digit, 9 wraps to 0 (no carry out).
  function automatic digit_t digit_inc(input digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Decrement one BCD digit, 0 wraps to 9 (no borrow out).
  function automatic digit_t digit_dec(input digit_t d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Rotate the one-hot digit select ones -> tens -> hundreds -> ones.
  function automatic logic [NUM_DIGITS-1:0] next_digit(input logic [NUM_DIGITS-1:0] sel);
    case (sel)
      DIGIT_ONES: return DIGIT_TENS;
      DIGIT_TENS: return DIGIT_HUNDREDS;
      default:    return DIGIT_ONES;
    endcase
  endfunction

  // Three legal BCD digits to binary; 999 fits in BIN_W bits so no overflow.
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
    return BIN_W'(bcd[11:8]) * BIN_W'(100)
         + BIN_W'(bcd[7:4])  * BIN_W'(10)
         + BIN_W'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/bcd_setpoint_entry_button_debouncer.sv
// One push-button conditioner: 2-FF synchroniser, stability counter and a
// released-to-pressed press pulse. The accepted level is also exported so the
// parent can measure how long the button has been held.
module bcd_setpoint_entry_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous raw button.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_q;
        press <= sync_q;   // only a released-to-pressed acceptance pulses
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_setpoint_entry.sv
// Operator entry of a 3-digit BCD setpoint from four raw push-buttons.
// up/down step the selected digit (wrapping, no carry), sel rotates the
// selected digit, load commits the working value as BCD and binary.
// Optional build macro: AUTO_REPEAT_EN adds auto-repeat on held up/down.
module bcd_setpoint_entry
  import bcd_setpoint_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_sel,
  input  logic                  btn_load,
  output logic [BCD_W-1:0]      edit_bcd,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [BCD_W-1:0]      setpoint_bcd,
  output logic [BIN_W-1:0]      setpoint_bin,
  output logic                  load_pulse,
  output logic                  dirty
);

  logic up_level, down_level, unused_sel_level, unused_load_level;
  logic up_press, down_press, sel_press, load_press;
  logic up_evt, down_evt;

  bcd_setpoint_entry_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .level(up_level), .press(up_press)
  );
  bcd_setpoint_entry_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down), .level(down_level), .press(down_press)
  );
  bcd_setpoint_entry_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .rst(rst), .btn_raw(btn_sel), .level(unused_sel_level), .press(sel_press)
  );
  bcd_setpoint_entry_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst(rst), .btn_raw(btn_load), .level(unused_load_level), .press(load_press)
  );

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [1:0]            held;
  logic [1:0][RPT_W-1:0] rpt_cnt;
  logic [1:0]            rpt_started;
  logic [1:0]            rpt_pulse;

  assign held = {down_level, up_level};

  // Hold timers: first step after REPEAT_DELAY held cycles, then every REPEAT_RATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt     <= '0;
      rpt_started <= '0;
      rpt_pulse   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_pulse[i] <= 1'b0;
        if (!held[i]) begin
          rpt_cnt[i]     <= '0;
          rpt_started[i] <= 1'b0;
        end else if (rpt_cnt[i] == (rpt_started[i] ? RPT_W'(REPEAT_RATE - 1)
                                                   : RPT_W'(REPEAT_DELAY - 1))) begin
          rpt_cnt[i]     <= '0;
          rpt_started[i] <= 1'b1;
          rpt_pulse[i]   <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign up_evt   = up_press   | rpt_pulse[0];
  assign down_evt = down_press | rpt_pulse[1];
`else
  // Without auto-repeat the held levels and repeat timing are not needed.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  logic unused_held;
  assign unused_held = up_level | down_level;

  assign up_evt   = up_press;
  assign down_evt = down_press;
`endif

  state_t                state, state_next;
  logic [BCD_W-1:0]      edit_next, edit_stepped;
  logic [NUM_DIGITS-1:0] sel_next;

  // Selected digit stepped up or down; other digits untouched.
  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    edit_stepped = edit_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel[i]) begin
        edit_stepped[i*DIGIT_W +: DIGIT_W] = up_evt ? digit_inc(edit_bcd[i*DIGIT_W +: DIGIT_W])
                                                    : digit_dec(edit_bcd[i*DIGIT_W +: DIGIT_W]);
      end
    end
  end

  // Next-state and next working value; load > sel > up/down, up+down ignored.
  always_comb begin
    state_next = state;
    edit_next  = edit_bcd;
    sel_next   = digit_sel;
    case (state)
      IDLE, EDIT: begin
        if (load_press) begin
          state_next = COMMIT;
        end else if (sel_press) begin
          sel_next = next_digit(digit_sel);
        end else if (up_evt ^ down_evt) begin
          edit_next  = edit_stepped;
          state_next = (edit_stepped == setpoint_bcd) ? IDLE : EDIT;
        end
      end
      default: state_next = IDLE;   // COMMIT lasts one cycle; presses dropped
    endcase
  end

  // State and registered outputs; commit copies the working value on entry to COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      edit_bcd     <= '0;
      digit_sel    <= DIGIT_ONES;
      setpoint_bcd <= '0;
      setpoint_bin <= '0;
      load_pulse   <= 1'b0;
      dirty        <= 1'b0;
    end else begin
      state      <= state_next;
      edit_bcd   <= edit_next;
      digit_sel  <= sel_next;
      load_pulse <= (state_next == COMMIT);
      dirty      <= (state_next == EDIT);
      if (state_next == COMMIT) begin
        setpoint_bcd <= edit_bcd;
        setpoint_bin <= bcd_to_bin(edit_bcd);
      end
    end
  end

endmodule

// File: tb/tb_bcd_setpoint_entry.sv
// Self-checking bench for bcd_setpoint_entry with DEBOUNCE_CYCLES=4:
// a directed vector table, hand-written corner sequences and random button
// operations checked against an arithmetic reference model.
module tb_bcd_setpoint_entry;

  localparam int DB     = 4;
  localparam int HOLD   = 8;
  localparam int SETTLE = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_sel, btn_load;
  logic [11:0] edit_bcd, setpoint_bcd;
  logic [2:0]  digit_sel;
  logic [9:0]  setpoint_bin;
  logic        load_pulse, dirty;

  bcd_setpoint_entry #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_sel     (btn_sel),
    .btn_load    (btn_load),
    .edit_bcd    (edit_bcd),
    .digit_sel   (digit_sel),
    .setpoint_bcd(setpoint_bcd),
    .setpoint_bin(setpoint_bin),
    .load_pulse  (load_pulse),
    .dirty       (dirty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Count load strobes away from the active edge; reset clears the tally.
  always @(negedge clk) begin
    if (rst) pulse_cnt = 0;
    else if (load_pulse) pulse_cnt = pulse_cnt + 1;
  end

  // Reference model: digit values, selected digit index, committed digits, loads.
  int m_dig[3];
  int m_sp[3];
  int m_sel;
  int m_loads;

  typedef struct {
    logic [3:0]  btn;     // {load, sel, down, up}
    logic [11:0] edit;
    logic [2:0]  sel;
    logic [11:0] sp;
    int          bin;
    logic        dirty;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_dig[i] = 0;
      m_sp[i]  = 0;
    end
    m_sel   = 0;
    m_loads = 0;
  endtask

  task automatic model_apply(input logic [3:0] m);
    if (m[3]) begin
      for (int i = 0; i < 3; i++) m_sp[i] = m_dig[i];
      m_loads++;
    end else if (m[2]) begin
      m_sel = (m_sel + 1) % 3;
    end else if (m[0] != m[1]) begin
      m_dig[m_sel] = m[0] ? (m_dig[m_sel] + 1) % 10 : (m_dig[m_sel] + 9) % 10;
    end
  endtask

  task automatic check_model(input string tag);
    logic [11:0] e, s;
    e = {m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]};
    s = {m_sp[2][3:0], m_sp[1][3:0], m_sp[0][3:0]};
    check({tag, ".edit"},  32'(edit_bcd),     32'(e));
    check({tag, ".sel"},   32'(digit_sel),    32'(1 << m_sel));
    check({tag, ".sp"},    32'(setpoint_bcd), 32'(s));
    check({tag, ".bin"},   32'(setpoint_bin), 32'(m_sp[2] * 100 + m_sp[1] * 10 + m_sp[0]));
    check({tag, ".dirty"}, 32'(dirty),        32'(e != s));
    check({tag, ".loads"}, 32'(pulse_cnt),    32'(m_loads));
  endtask

  task automatic drive(input logic [3:0] m);
    btn_up   = m[0];
    btn_down = m[1];
    btn_sel  = m[2];
    btn_load = m[3];
  endtask

  task automatic press(input logic [3:0] m);
    drive(m);
    tick(HOLD);
    drive(4'b0000);
    tick(SETTLE);
  endtask

  initial begin
    logic [3:0] m;
    bit         seen;

    vecs[0]  = '{4'b0001, 12'h001, 3'b001, 12'h000,   0, 1'b1};
    vecs[1]  = '{4'b0001, 12'h002, 3'b001, 12'h000,   0, 1'b1};
    vecs[2]  = '{4'b0001, 12'h003, 3'b001, 12'h000,   0, 1'b1};
    vecs[3]  = '{4'b0100, 12'h003, 3'b010, 12'h000,   0, 1'b1};
    vecs[4]  = '{4'b0001, 12'h013, 3'b010, 12'h000,   0, 1'b1};
    vecs[5]  = '{4'b0001, 12'h023, 3'b010, 12'h000,   0, 1'b1};
    vecs[6]  = '{4'b1000, 12'h023, 3'b010, 12'h023,  23, 1'b0};
    vecs[7]  = '{4'b0100, 12'h023, 3'b100, 12'h023,  23, 1'b0};
    vecs[8]  = '{4'b0100, 12'h023, 3'b001, 12'h023,  23, 1'b0};
    vecs[9]  = '{4'b0010, 12'h022, 3'b001, 12'h023,  23, 1'b1};
    vecs[10] = '{4'b0010, 12'h021, 3'b001, 12'h023,  23, 1'b1};
    vecs[11] = '{4'b0010, 12'h020, 3'b001, 12'h023,  23, 1'b1};
    vecs[12] = '{4'b0010, 12'h029, 3'b001, 12'h023,  23, 1'b1};
    vecs[13] = '{4'b0001, 12'h020, 3'b001, 12'h023,  23, 1'b1};
    vecs[14] = '{4'b0001, 12'h021, 3'b001, 12'h023,  23, 1'b1};
    vecs[15] = '{4'b0001, 12'h022, 3'b001, 12'h023,  23, 1'b1};
    vecs[16] = '{4'b0001, 12'h023, 3'b001, 12'h023,  23, 1'b0};
    vecs[17] = '{4'b0011, 12'h023, 3'b001, 12'h023,  23, 1'b0};
    vecs[18] = '{4'b1001, 12'h023, 3'b001, 12'h023,  23, 1'b0};
    vecs[19] = '{4'b0101, 12'h023, 3'b010, 12'h023,  23, 1'b0};
    vecs[20] = '{4'b0010, 12'h013, 3'b010, 12'h023,  23, 1'b1};
    vecs[21] = '{4'b1110, 12'h013, 3'b010, 12'h013,  13, 1'b0};
    vecs[22] = '{4'b0100, 12'h013, 3'b100, 12'h013,  13, 1'b0};
    vecs[23] = '{4'b0010, 12'h913, 3'b100, 12'h013,  13, 1'b1};
    vecs[24] = '{4'b1000, 12'h913, 3'b100, 12'h913, 913, 1'b0};

    rst = 1'b1;
    drive(4'b0000);
    model_reset();
    tick(3);
    check("rst.edit",  32'(edit_bcd),     32'h000);
    check("rst.sel",   32'(digit_sel),    32'b001);
    check("rst.bin",   32'(setpoint_bin), 32'd0);
    check("rst.pulse", 32'(load_pulse),   32'd0);
    rst = 1'b0;
    tick(2);
    check_model("post_rst");

    // Directed vectors, expectations hand-derived.
    for (int i = 0; i < 25; i++) begin
      press(vecs[i].btn);
      model_apply(vecs[i].btn);
      check($sformatf("vec%0d.edit", i),  32'(edit_bcd),     32'(vecs[i].edit));
      check($sformatf("vec%0d.sel", i),   32'(digit_sel),    32'(vecs[i].sel));
      check($sformatf("vec%0d.sp", i),    32'(setpoint_bcd), 32'(vecs[i].sp));
      check($sformatf("vec%0d.bin", i),   32'(setpoint_bin), 32'(vecs[i].bin));
      check($sformatf("vec%0d.dirty", i), 32'(dirty),        32'(vecs[i].dirty));
      check($sformatf("vec%0d.loads", i), 32'(pulse_cnt),    32'(m_loads));
    end

    // A 3-cycle glitch is shorter than the debounce window: no change.
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(SETTLE);
    check_model("glitch3");

    // Held for 6 cycles: exactly one increment.
    btn_up = 1'b1;
    tick(6);
    btn_up = 1'b0;
    tick(SETTLE);
    model_apply(4'b0001);
    check_model("held6");

    // Reset during the COMMIT cycle: setpoint returns to 0, no strobe survives.
    press(4'b0010);
    model_apply(4'b0010);
    btn_load = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (load_pulse === 1'b1) seen = 1'b1;
    end
    check("commit_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_commit.sp",    32'(setpoint_bcd), 32'h000);
    check("mid_commit.bin",   32'(setpoint_bin), 32'd0);
    check("mid_commit.pulse", 32'(load_pulse),   32'd0);
    btn_load = 1'b0;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(SETTLE);
    check_model("after_mid_commit");

    // Random single and coincident presses against the reference model.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: m = 4'b0001;
        3, 4:    m = 4'b0010;
        5:       m = 4'b0100;
        6:       m = 4'b1000;
        7:       m = 4'b0011;
        8:       m = 4'b1000 | 4'($urandom_range(1, 7));
        default: m = 4'b0101;
      endcase
      press(m);
      model_apply(m);
      check_model($sformatf("rnd%0d", n));
    end

`ifdef AUTO_REPEAT_EN
    // Hold up long enough for four repeat steps after the initial press.
    btn_up = 1'b1;
    tick(22);
    btn_up = 1'b0;
    tick(SETTLE);
    repeat (5) model_apply(4'b0001);
    check_model("auto_repeat");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
